// File: rtl/seg_disp_mux.sv
// Multiplexed seven-segment scanner. Digit data is double-buffered and taken up
// at frame boundaries. Supports digit enables, DP mask, leading-zero blanking and blink.
module seg_disp_mux #(
  parameter int DIGITS         = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLINK_FRAMES   = 64,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  blank_lz,
  input  logic                  blink,
  output logic [6:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  DP,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Active-high gfedcba patterns for hex digits 0-F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    unique case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                blink_off_q, blink_off_d;
  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                pending_q, pending_d;
  logic [4*DIGITS-1:0] active_data_q, active_data_d;
  logic [DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                dp_q, dp_d;
  logic                frame_tick_q, frame_tick_d;

  logic                last_slot, wrap;
  logic [DIGITS-1:0]   lz_blank, sel;
  logic                zeros_above, cur_dp, cur_en, cur_blank;
  logic [3:0]          cur_nib;
  logic [6:0]          cur_pat;

  // Scan timing, blink phase and the shadow/active buffer handoff.
  always_comb begin
    last_slot     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    wrap          = last_slot && (idx_q == IDX_W'(DIGITS - 1));
    cnt_d         = last_slot ? '0 : cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    frame_tick_d  = wrap;
    blink_cnt_d   = blink_cnt_q;
    blink_off_d   = blink_off_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;

    if (last_slot) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end

    if (!blink) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    if (load) begin
      shadow_data_d = data;
      shadow_dp_d   = dp_mask;
      pending_d     = 1'b1;
    end
    // A load coinciding with the wrap goes straight through to the display.
    if (wrap) begin
      if (load) begin
        active_data_d = data;
        active_dp_d   = dp_mask;
        pending_d     = 1'b0;
      end else if (pending_q) begin
        active_data_d = shadow_data_q;
        active_dp_d   = shadow_dp_q;
        pending_d     = 1'b0;
      end
    end
  end

  // Digit selection and decode; anode and segments register together to avoid ghosting.
  always_comb begin
    lz_blank    = '0;
    zeros_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeros_above = zeros_above && (active_data_q[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz && zeros_above;
    end

    sel       = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel[i]    = 1'b1;
        cur_nib   = active_data_q[4*i +: 4];
        cur_dp    = active_dp_q[i];
        cur_en    = digit_en[i];
        cur_blank = lz_blank[i];
      end
    end

    cur_pat = hex_to_seg(cur_nib);
    seg_d   = cur_blank ? SEG_OFF : ((SEG_ACTIVE_LOW != 0) ? ~cur_pat : cur_pat);
    dp_d    = cur_dp ? ~DP_OFF : DP_OFF;
    an_d    = AN_OFF;
    if (cur_en && !(blink && blink_off_q)) begin
      an_d = AN_OFF ^ sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_off_q   <= 1'b0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
      dp_q          <= DP_OFF;
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_off_q   <= blink_off_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign SEG        = seg_q;
  assign AN         = an_q;
  assign DP         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
